// File: rtl/fifo_1i1o_reader.sv
// Purpose: read-side adapter for a 1W/1R FIFO; issues reads, absorbs the 1-cycle SRAM latency in a 2-entry skid.
// Latency: FIFO non-empty to o_valid is 2 cycles (issue, ack/capture); 1 beat/cycle sustained with i_ready high.
// Backpressure: o_valid/o_data hold while ~i_ready; reads stop once buffered + in-flight entries reach 2.
//
// Ports:
//   i_clk, i_rst (async, active-high), i_flush (sync, same cycle as FIFO flush)
//   o_f_r_e / i_f_r_avail / i_f_r_ack / i_f_r_data : FIFO read port (ack one cycle after o_f_r_e)
//   o_valid / o_data / i_ready                    : downstream valid/ready stream
//   o_beat_cnt / o_stall_cnt                      : saturating statistics counters
// Optional feature macro: FIFO_1I1O_READER_STATS_EN (counters present when defined, tied to 0 otherwise).
module fifo_1i1o_reader #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  output logic                 o_f_r_e,
  input  logic                 i_f_r_avail,
  input  logic                 i_f_r_ack,
  input  logic [WIDTH-1:0]     i_f_r_data,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  input  logic                 i_ready,
  output logic [CNT_WIDTH-1:0] o_beat_cnt,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);

  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic             pop;
  logic             push;
  logic [2:0]       pending;

  assign o_valid = (occ_q != 2'd0);
  assign o_data  = ent0_q;
  assign pop     = o_valid & i_ready;

  // Slots that will be committed after this cycle's pop. occ + inflight never
  // exceeds 2 and a pop implies occ >= 1, so this cannot underflow.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign o_f_r_e = i_f_r_avail & ~i_flush & ~i_rst & (pending < 3'd2);

  // A late ack for a read that preceded a flush is dropped here.
  assign push = i_f_r_ack & inflight_q & ~i_flush;

  always_comb begin
    occ_d      = occ_q;
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    inflight_d = o_f_r_e;
    if (i_flush) begin
      occ_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_d = i_f_r_data;
          else               ent1_d = i_f_r_data;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // Pop frees the head first, then the new beat lands in the first free slot.
          if (occ_q == 2'd1) begin
            ent0_d = i_f_r_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = i_f_r_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

`ifdef FIFO_1I1O_READER_STATS_EN
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!i_flush) begin
      if (pop && (beat_cnt_q != {CNT_WIDTH{1'b1}}))
        beat_cnt_d = beat_cnt_q + 1'b1;
      if (o_valid && !i_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_beat_cnt  = beat_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_beat_cnt  = '0;
  assign o_stall_cnt = '0;
`endif

`ifndef SYNTHESIS
  // An ack with no read outstanding means the FIFO and this adapter disagree.
  ack_without_read: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_f_r_ack && !inflight_q));
`endif

endmodule

// File: tb/tb_fifo_1i1o_reader.sv
module tb_fifo_1i1o_reader;

  logic        clk = 1'b0;
  logic        rst, flush, ready, avail, ack;
  logic [31:0] rdata;
  logic        re, valid;
  logic [31:0] data;
  logic [15:0] beat_cnt, stall_cnt;

  always #5 clk = ~clk;

  fifo_1i1o_reader #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .o_f_r_e     (re),
    .i_f_r_avail (avail),
    .i_f_r_ack   (ack),
    .i_f_r_data  (rdata),
    .o_valid     (valid),
    .o_data      (data),
    .i_ready     (ready),
    .o_beat_cnt  (beat_cnt),
    .o_stall_cnt (stall_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: FIFO contents, and reads issued but not yet delivered (in FIFO order).
  logic [31:0] fifo_m[$];
  logic [31:0] exp_m[$];
  logic [31:0] out_log[$];
  logic [31:0] in_log[$];
  int          pop_cyc[$];
  bit          inflight_b = 1'b0;
  int          issued = 0, pops = 0;
  int          beat_ref = 0, stall_ref = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] d);
    fifo_m.push_back(d);
    avail = 1'b1;
  endtask

  task automatic assert_reset();
    rst        = 1'b1;
    inflight_b = 1'b0;
    beat_ref   = 0;
    stall_ref  = 0;
    exp_m.delete();
  endtask

  // One clock: check outputs at the falling edge, then advance the FIFO model.
  task automatic tick();
    bit ev, pe, er;
    int outstanding;
    cyc++;
    @(negedge clk);
    outstanding = exp_m.size();
    ev = !rst && ((outstanding - int'(inflight_b)) > 0);
    pe = ev && ready;
    er = !rst && !flush && avail && ((outstanding - int'(pe)) < 2);
    chk("o_valid", {31'd0, valid}, {31'd0, ev});
    chk("o_f_r_e", {31'd0, re}, {31'd0, er});
    if (ev)  chk("o_data", data, exp_m[0]);
    if (rst) chk("o_data_rst", data, 32'd0);
`ifdef FIFO_1I1O_READER_STATS_EN
    chk("beat_cnt", {16'd0, beat_cnt}, beat_ref);
    chk("stall_cnt", {16'd0, stall_cnt}, stall_ref);
`else
    chk("beat_cnt_off", {16'd0, beat_cnt}, 32'd0);
    chk("stall_cnt_off", {16'd0, stall_cnt}, 32'd0);
`endif
    if (!rst && !flush) begin
      if (pe) beat_ref++;
      if (ev && !ready) stall_ref++;
    end
    if (pe) begin
      pops++;
      pop_cyc.push_back(cyc);
      out_log.push_back(exp_m.pop_front());
    end
    @(posedge clk);
    #1;
    ack   = 1'b0;
    rdata = $urandom;
    if (flush || rst) begin
      exp_m.delete();
      if (flush) fifo_m.delete();
    end
    if (er) begin
      rdata = fifo_m.pop_front();
      exp_m.push_back(rdata);
      ack = 1'b1;
      issued++;
    end
    inflight_b = er;
    avail = (fifo_m.size() != 0);
  endtask

  initial begin
    int t0, i0, p0, o0, wr;
    bit pv;
    flush = 1'b0;
    ready = 1'b0;
    avail = 1'b0;
    ack   = 1'b0;
    rdata = 32'd0;
    assert_reset();

    // Reset held for 2 cycles with entries waiting in the FIFO.
    push(32'hA); push(32'hB); push(32'hC);
    tick(); tick();
    rst   = 1'b0;
    ready = 1'b1;
    p0 = pops;
    for (int k = 0; k < 8; k++) tick();
    chk("rst_drain_pops", pops - p0, 3);

    // Streaming with i_ready high: beats on t0+2 .. t0+5.
    pop_cyc.delete();
    t0 = cyc + 1;
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    for (int k = 0; k < 8; k++) tick();
    chk("stream_pops", pop_cyc.size(), 4);
    for (int k = 0; k < 4 && k < pop_cyc.size(); k++)
      chk("stream_beat_cycle", pop_cyc[k], t0 + 2 + k);

    // Backpressure: exactly 2 reads outstanding, head stable.
    ready = 1'b0;
    i0 = issued;
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    for (int k = 0; k < 5; k++) tick();
    chk("bp_issued", issued - i0, 2);
    chk("bp_head", data, 32'h11);
    chk("bp_valid", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    p0 = pops;
    for (int k = 0; k < 8; k++) tick();
    chk("bp_drain_pops", pops - p0, 4);

    // Flush with one beat buffered and an ack arriving in the flush cycle.
    ready = 1'b0;
    push(32'h61); push(32'h62); push(32'h63); push(32'h64);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, valid}, 32'd0);
    push(32'h55);
    ready = 1'b1;
    p0 = pops;
    for (int k = 0; k < 10 && pops == p0; k++) tick();
    chk("flush_next_pops", pops - p0, 1);
    if (pops > p0) chk("flush_next_beat", out_log[out_log.size() - 1], 32'h55);

    // Wrap: 20 random beats through a depth-8 FIFO with random i_ready.
    in_log.delete();
    o0 = out_log.size();
    p0 = pops;
    wr = 0;
    for (int k = 0; k < 600 && (pops - p0) < 20; k++) begin
      ready = 1'($urandom_range(0, 1));
      if (wr < 20 && fifo_m.size() < 8 && $urandom_range(0, 3) != 0) begin
        in_log.push_back($urandom);
        push(in_log[in_log.size() - 1]);
        wr++;
      end
      tick();
    end
    chk("wrap_pops", pops - p0, 20);
    for (int k = 0; k < 20 && (o0 + k) < out_log.size(); k++)
      chk("wrap_order", out_log[o0 + k], in_log[k]);

    // Reset mid-burst with a read in flight.
    ready = 1'b0;
    push(32'h71); push(32'h72); push(32'h73);
    tick(); tick();
    assert_reset();
    fifo_m.delete();
    avail = 1'b0;
    tick();
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_data", data, 32'd0);
    rst = 1'b0;
    tick();

    // Statistics: 10 beats with exactly 3 stall cycles.
    for (int k = 0; k < 10; k++) push(32'h100 + k);
    for (int k = 0; k < 80 && beat_ref < 10; k++) begin
      pv = (exp_m.size() - int'(inflight_b)) > 0;
      ready = !(pv && stall_ref < 3 && (k % 2 == 0));
      tick();
    end
    ready = 1'b1;
    tick();
`ifdef FIFO_1I1O_READER_STATS_EN
    chk("stats_beats", {16'd0, beat_cnt}, 32'd10);
    chk("stats_stalls", {16'd0, stall_cnt}, 32'd3);
`else
    chk("stats_beats_off", {16'd0, beat_cnt}, 32'd0);
    chk("stats_stalls_off", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
